// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer countdown core.
//   - state_t      : IDLE / RUN / PAUSE / ALARM controller states
//   - bcd_t        : one 4-bit BCD digit
//   - BCD_MAX      : largest value of a decimal digit (9)
//   - SEC_TENS_MAX : largest value of the seconds-tens digit (5)
//   - bcd_inc      : wrap-around increment of a single digit
package egg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    // Increment a digit, wrapping to 0 after max.
    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/egg_countdown_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick.
//   Parameter DIV : cycles per tick (counter runs 0..DIV-1).
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : count enable; the counter holds its value while low
//   clr           : synchronous clear, overrides en
//   tick          : high in the cycle where the counter sits at DIV-1 and is
//                   enabled, i.e. on the edge where it wraps back to 0
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/egg_countdown.sv
// egg_countdown: BCD MM:SS countdown core of the egg timer.
//   Parameter TICK_DIV : clock cycles per one-second count step (>= 2)
//   Parameter HALF_DIV : blink half-period in cycles (only with the blink option)
//   Optional feature   : define EGG_TIMER_BLINK_EN to flash the display in ALARM
//                        via the blank output; otherwise blank is tied 0.
//   clk, rst_n         : clock, asynchronous active-low reset
//   sec_inc / min_inc  : one-cycle pulses, add one second / one minute
//   start_stop         : one-cycle pulse, start / pause / acknowledge alarm
//   clear              : one-cycle pulse, abort to IDLE with 00:00
//   sec_ones..min_tens : registered BCD digits for the 7-segment decoders
//   running / alarm    : registered, high in RUN / ALARM
//   blank              : registered display blank request
module egg_countdown
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000
`ifdef EGG_TIMER_BLINK_EN
    , parameter int HALF_DIV = TICK_DIV / 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_inc,
    input  logic       min_inc,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       alarm,
    output logic       blank
);

    state_t state;

    logic count_zero;
    logic take_start;
    logic pre_en;
    logic pre_clr;
    logic tick;

    bcd_t dec_so, dec_st, dec_mo, dec_mt;
    logic dec_zero;
    bcd_t ed_so, ed_st, ed_mo, ed_mt;

    assign count_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                        (min_ones == 4'd0) && (min_tens == 4'd0);

    // start_stop is only refused in IDLE at 00:00; in that case the inc
    // pulses of the same cycle still edit the count.
    assign take_start = start_stop && !clear &&
                        ((state != ST_IDLE) || !count_zero);

    // The prescaler freezes in the cycle that pauses, so a resume continues
    // exactly where the run stopped. It sits at 0 while IDLE or ALARM.
    assign pre_en  = (state == ST_RUN) && !start_stop && !clear;
    assign pre_clr = clear || (state == ST_IDLE) || (state == ST_ALARM);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_sec_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    // Decrement with borrow chain: ones -> tens -> minutes.
    always_comb begin
        logic b0, b1, b2;
        b0     = (sec_ones == 4'd0);
        dec_so = b0 ? BCD_MAX : sec_ones - 4'd1;
        b1     = b0 && (sec_tens == 4'd0);
        dec_st = b0 ? ((sec_tens == 4'd0) ? SEC_TENS_MAX : sec_tens - 4'd1) : sec_tens;
        b2     = b1 && (min_ones == 4'd0);
        dec_mo = b1 ? ((min_ones == 4'd0) ? BCD_MAX : min_ones - 4'd1) : min_ones;
        dec_mt = b2 ? min_tens - 4'd1 : min_tens;
        dec_zero = (dec_so == 4'd0) && (dec_st == 4'd0) &&
                   (dec_mo == 4'd0) && (dec_mt == 4'd0);
    end

    // Edited count: seconds wrap 59 -> 00 without touching minutes,
    // minutes wrap 99 -> 00. Both pulses may apply in one cycle.
    always_comb begin
        ed_so = sec_ones;
        ed_st = sec_tens;
        ed_mo = min_ones;
        ed_mt = min_tens;
        if (sec_inc) begin
            ed_so = bcd_inc(sec_ones, BCD_MAX);
            if (sec_ones == BCD_MAX) ed_st = bcd_inc(sec_tens, SEC_TENS_MAX);
        end
        if (min_inc) begin
            ed_mo = bcd_inc(min_ones, BCD_MAX);
            if (min_ones == BCD_MAX) ed_mt = bcd_inc(min_tens, BCD_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            running  <= 1'b0;
            alarm    <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            running  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        sec_ones <= ed_so;
                        sec_tens <= ed_st;
                        min_ones <= ed_mo;
                        min_tens <= ed_mt;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        sec_ones <= dec_so;
                        sec_tens <= dec_st;
                        min_ones <= dec_mo;
                        min_tens <= dec_mt;
                        if (dec_zero) begin
                            state   <= ST_ALARM;
                            running <= 1'b0;
                            alarm   <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        // A pause edited down to 00:00 has nothing to run.
                        if (count_zero) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end else begin
                        sec_ones <= ed_so;
                        sec_tens <= ed_st;
                        min_ones <= ed_mo;
                        min_tens <= ed_mt;
                    end
                end
                ST_ALARM: begin
                    if (start_stop) begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

`ifdef EGG_TIMER_BLINK_EN
    logic stay_alarm;
    logic blink_tick;

    // The blink counter only advances while ALARM persists and is zeroed on
    // the exit edge, so every ALARM entry starts with a full unblanked half.
    assign stay_alarm = (state == ST_ALARM) && !start_stop && !clear;

    tick_gen #(
        .DIV (HALF_DIV)
    ) u_blink_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stay_alarm),
        .clr   (!stay_alarm),
        .tick  (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= 1'b0;
        end else if (stay_alarm) begin
            if (blink_tick) blank <= ~blank;
        end else begin
            blank <= 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_egg_countdown.sv
// Testbench for egg_countdown with TICK_DIV = 4: table of directed vectors
// followed by hand-written multi-cycle sequences.
module tb_egg_countdown;

    localparam int TICK = 4;

    logic       clk;
    logic       rst_n;
    logic       sec_inc, min_inc, start_stop, clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, alarm, blank;

    int n_checks;
    int n_pass;

    egg_countdown #(
        .TICK_DIV (TICK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_inc    (sec_inc),
        .min_inc    (min_inc),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .alarm      (alarm),
        .blank      (blank)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        si, mi, ss, cl;
        int          n;        // cycles: pulse cycle + (n-1) idle cycles
        logic [15:0] digits;   // {min_tens, min_ones, sec_tens, sec_ones}
        logic        run, alm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic si, mi, ss, cl, input int n,
                                input logic [15:0] d, input logic r, a);
        vec_t v;
        v.si = si; v.mi = mi; v.ss = ss; v.cl = cl;
        v.n = n; v.digits = d; v.run = r; v.alm = a;
        return v;
    endfunction

    function automatic logic [15:0] digits_now();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk_state(input string name, input logic [15:0] d, input logic r, input logic a);
        chk({name, ".digits"}, digits_now(), d);
        chk({name, ".running"}, {15'd0, running}, {15'd0, r});
        chk({name, ".alarm"}, {15'd0, alarm}, {15'd0, a});
    endtask

    // driver: one clock cycle with the given pulses, sampled 1 time unit
    // after the active edge
    task automatic cyc(input logic si, mi, ss, cl);
        @(negedge clk);
        sec_inc = si; min_inc = mi; start_stop = ss; clear = cl;
        @(posedge clk);
        #1;
        sec_inc = 0; min_inc = 0; start_stop = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        sec_inc = 0; min_inc = 0; start_stop = 0; clear = 0;

        // test 1: load 01:05, run 4 cycles -> 01:04, 20 more -> 00:59
        vecs.push_back(mk(0,1,0,0, 1, 16'h0100, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0101, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0102, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0103, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0104, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0105, 0, 0));
        vecs.push_back(mk(0,0,1,0, 1, 16'h0105, 1, 0));
        vecs.push_back(mk(0,0,0,0, 3, 16'h0105, 1, 0));
        vecs.push_back(mk(0,0,0,0, 1, 16'h0104, 1, 0));
        vecs.push_back(mk(0,0,0,0, 20, 16'h0059, 1, 0));
        vecs.push_back(mk(0,0,0,1, 1, 16'h0000, 0, 0));
        // test 2: 00:02 down to alarm, acknowledge
        vecs.push_back(mk(1,0,0,0, 1, 16'h0001, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0002, 0, 0));
        vecs.push_back(mk(0,0,1,0, 1, 16'h0002, 1, 0));
        vecs.push_back(mk(0,0,0,0, 4, 16'h0001, 1, 0));
        vecs.push_back(mk(0,0,0,0, 3, 16'h0001, 1, 0));
        vecs.push_back(mk(0,0,0,0, 1, 16'h0000, 0, 1));
        vecs.push_back(mk(0,0,0,0, 3, 16'h0000, 0, 1));
        vecs.push_back(mk(0,0,1,0, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0,0,1,0, 2, 16'h0000, 0, 0));   // IDLE 00:00 start ignored
        // test 5: start_stop wins over sec_inc; clear wins over start_stop
        vecs.push_back(mk(1,0,0,0, 1, 16'h0001, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0002, 0, 0));
        vecs.push_back(mk(1,0,0,0, 1, 16'h0003, 0, 0));
        vecs.push_back(mk(1,0,1,0, 1, 16'h0003, 1, 0));
        vecs.push_back(mk(0,0,0,0, 2, 16'h0003, 1, 0));
        vecs.push_back(mk(0,0,1,1, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0,0,0,0, 6, 16'h0000, 0, 0));
        // both incs in one cycle
        vecs.push_back(mk(1,1,0,0, 1, 16'h0101, 0, 0));
        vecs.push_back(mk(0,0,0,1, 1, 16'h0000, 0, 0));

        // reset state
        #12;
        chk_state("reset", 16'h0000, 0, 0);
        chk("reset.blank", {15'd0, blank}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            cyc(vecs[k].si, vecs[k].mi, vecs[k].ss, vecs[k].cl);
            idle(vecs[k].n - 1);
            chk_state($sformatf("vec%0d", k), vecs[k].digits, vecs[k].run, vecs[k].alm);
        end

        // test 3: seconds wrap 59 -> 00, minutes wrap 99 -> 00
        for (int i = 1; i <= 60; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 10) chk("sec_inc10", digits_now(), 16'h0010);
            if (i == 59) chk("sec_inc59", digits_now(), 16'h0059);
        end
        chk("sec_wrap", digits_now(), 16'h0000);
        for (int i = 1; i <= 100; i++) begin
            cyc(0, 1, 0, 0);
            if (i == 99) chk("min_inc99", digits_now(), 16'h9900);
        end
        chk("min_wrap", digits_now(), 16'h0000);

        // test 4: pause keeps count and prescaler
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 1, 0);
        chk_state("pause", 16'h0010, 0, 0);
        idle(10);
        chk_state("pause_hold", 16'h0010, 0, 0);
        cyc(0, 0, 1, 0);
        chk_state("resume", 16'h0010, 1, 0);
        idle(1);
        chk("resume+1", digits_now(), 16'h0010);
        idle(1);
        chk("resume+2", digits_now(), 16'h0009);
        // pause, edit to 00:00 (09 + 51 wraps), start_stop goes to IDLE
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 51; i++) cyc(1, 0, 0, 0);
        chk_state("pause_edit", 16'h0000, 0, 0);
        cyc(0, 0, 1, 0);
        idle(TICK * 2);
        chk_state("pause_zero_idle", 16'h0000, 0, 0);
        cyc(0, 0, 1, 0);
        chk_state("idle_zero_start", 16'h0000, 0, 0);

        // test 6: asynchronous reset mid-RUN
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(5);
        chk_state("pre_reset", 16'h0004, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_state("async_reset", 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(TICK + 1);
        chk_state("after_reset", 16'h0000, 0, 0);

        // blink pattern in ALARM (HALF_DIV defaults to TICK_DIV/2 = 2)
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(TICK);
        chk_state("alarm_entry", 16'h0000, 0, 1);
        begin
            logic [4:0] exp_blank;
`ifdef EGG_TIMER_BLINK_EN
            exp_blank = 5'b01100;   // read order bit0..bit4: 0,0,1,1,0
`else
            exp_blank = 5'b00000;
`endif
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("blank%0d", i), {15'd0, blank}, {15'd0, exp_blank[i]});
                idle(1);
            end
        end
        cyc(0, 0, 0, 1);
        chk_state("alarm_clear", 16'h0000, 0, 0);
        chk("blank_after_clear", {15'd0, blank}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
